// File: rtl/ecc_pkg.sv
// Shared widths and FSM encoding for the SECDED memory responder.
package ecc_pkg;
   localparam int DATA_W = 32;
   localparam int CODE_W = 39;
   localparam int SYN_W  = 6;
   localparam int ST_W   = 3;

   localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
   localparam logic [ST_W-1:0] ST_ACCESS = 3'd1;
   localparam logic [ST_W-1:0] ST_CHECK  = 3'd2;
   localparam logic [ST_W-1:0] ST_SCRUB  = 3'd3;
   localparam logic [ST_W-1:0] ST_RESP   = 3'd4;

   // Powers of two (and 0) hold check/parity bits; every other position carries data.
   function automatic logic is_chk_pos(input int unsigned p);
      return (p & (p - 1)) == 0;
   endfunction
endpackage

// File: rtl/secded_codec.sv
// Combinational SECDED(39,32) codec: encode, syndrome and single-bit correct.
module secded_codec
   import ecc_pkg::*;
(
   input  logic [DATA_W-1:0] enc_data,
   output logic [CODE_W-1:0] enc_code,
   input  logic [CODE_W-1:0] dec_code,
   output logic [DATA_W-1:0] dec_data,
   output logic [SYN_W-1:0]  dec_syn,
   output logic              dec_s_err,
   output logic              dec_d_err
);
   always_comb begin
      int j;
      logic [SYN_W-1:0] cp;
      enc_code = '0;
      j = 0;
      for (int p = 1; p < CODE_W; p++) begin
         if (!is_chk_pos(p)) begin
            enc_code[p] = enc_data[j];
            j++;
         end
      end
      // XOR of set data positions is exactly the check pattern that zeroes the syndrome.
      cp = '0;
      for (int p = 1; p < CODE_W; p++)
         if (enc_code[p]) cp = cp ^ SYN_W'(p);
      for (int k = 0; k < SYN_W; k++)
         enc_code[1 << k] = cp[k];
      enc_code[0] = ^enc_code[CODE_W-1:1];
   end

   always_comb begin
      int j;
      logic par_bad;
      logic [CODE_W-1:0] fix;
      dec_syn = '0;
      for (int p = 1; p < CODE_W; p++)
         if (dec_code[p]) dec_syn = dec_syn ^ SYN_W'(p);
      par_bad   = ^dec_code;
      fix       = dec_code;
      dec_s_err = 1'b0;
      dec_d_err = 1'b0;
      if (dec_syn == '0) begin
         dec_s_err = par_bad;
      end else if (par_bad && (int'(dec_syn) < CODE_W)) begin
         fix[dec_syn] = ~fix[dec_syn];
         dec_s_err    = 1'b1;
      end else begin
         dec_d_err = 1'b1;
      end
      dec_data = '0;
      j = 0;
      for (int p = 1; p < CODE_W; p++) begin
         if (!is_chk_pos(p)) begin
            dec_data[j] = fix[p];
            j++;
         end
      end
   end
endmodule

// File: rtl/ecc_mem_responder.sv
// Single-port ECC-protected word memory with request/response handshake and scrub-on-read.
module ecc_mem_responder
   import ecc_pkg::*;
#(
   parameter int DEPTH    = 64,
   parameter bit SCRUB_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [CODE_W-1:0] inj_mask,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              s_err,
   output logic              d_err,
   output logic [15:0]       s_cnt,
   output logic [15:0]       d_cnt
);
   localparam int IDX_W = $clog2(DEPTH);

   logic [ST_W-1:0]   state;
   logic              we_q;
   logic [IDX_W-1:0]  idx_q;
   logic [DATA_W-1:0] wdata_q;
   logic [CODE_W-1:0] inj_q;
   logic [CODE_W-1:0] code_q;
   logic [DATA_W-1:0] rdata_q;
   logic              s_q, d_q;
   logic [CODE_W-1:0] mem [DEPTH];

   logic [DATA_W-1:0] enc_data, dec_data;
   logic [CODE_W-1:0] enc_code;
   logic [SYN_W-1:0]  dec_syn;
   logic              dec_s_err, dec_d_err;
   logic              mem_we;
   logic [CODE_W-1:0] mem_wdata;
   logic              unused_bits;

   assign unused_bits = ^{req_addr[31:IDX_W+2], req_addr[1:0], dec_syn};

   assign req_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);
   assign rsp_rdata = rsp_valid ? rdata_q : '0;
   assign s_err     = rsp_valid & s_q;
   assign d_err     = rsp_valid & d_q;

   // One codec serves both the host write and the scrub write-back.
   assign enc_data  = (state == ST_SCRUB) ? rdata_q : wdata_q;
   assign mem_we    = ((state == ST_ACCESS) && we_q) || (state == ST_SCRUB);
   assign mem_wdata = (state == ST_ACCESS) ? (enc_code ^ inj_q) : enc_code;

   secded_codec u_codec (
      .enc_data  (enc_data),
      .enc_code  (enc_code),
      .dec_code  (code_q),
      .dec_data  (dec_data),
      .dec_syn   (dec_syn),
      .dec_s_err (dec_s_err),
      .dec_d_err (dec_d_err)
   );

   // Storage and request payload carry no reset; commit is gated by the reset FSM state.
   always_ff @(posedge clk) begin
      if (mem_we) mem[idx_q] <= mem_wdata;
      if (state == ST_ACCESS) code_q <= mem[idx_q];
      if (req_ready && req_valid) begin
         we_q    <= req_we;
         idx_q   <= req_addr[IDX_W+1:2];
         wdata_q <= req_wdata;
         inj_q   <= inj_mask;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         rdata_q <= '0;
         s_q     <= 1'b0;
         d_q     <= 1'b0;
         s_cnt   <= '0;
         d_cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  rdata_q <= '0;
                  s_q     <= 1'b0;
                  d_q     <= 1'b0;
                  state   <= ST_ACCESS;
               end
            end
            ST_ACCESS: state <= we_q ? ST_RESP : ST_CHECK;
            ST_CHECK: begin
               rdata_q <= dec_data;
               s_q     <= dec_s_err;
               d_q     <= dec_d_err;
               state   <= (dec_s_err && SCRUB_EN) ? ST_SCRUB : ST_RESP;
            end
            ST_SCRUB: state <= ST_RESP;
            ST_RESP: begin
               if (s_q && (s_cnt != 16'hFFFF)) s_cnt <= s_cnt + 16'd1;
               if (d_q && (d_cnt != 16'hFFFF)) d_cnt <= d_cnt + 16'd1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ecc_mem_responder.sv
// Directed + randomized bench for ecc_mem_responder against a word/error-mask model.
module tb_ecc_mem_responder;
   import ecc_pkg::*;
   localparam int DEPTH = 64;
   localparam int IDX_W = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [38:0] inj_mask;
   logic        rsp_valid, s_err, d_err;
   logic [31:0] rsp_rdata;
   logic [15:0] s_cnt, d_cnt;

   ecc_mem_responder #(.DEPTH(DEPTH), .SCRUB_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .inj_mask(inj_mask), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .s_err(s_err), .d_err(d_err), .s_cnt(s_cnt), .d_cnt(d_cnt)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Model: the intended data word plus the set of codeword positions flipped by injection.
   logic [31:0] m_data [DEPTH];
   logic [38:0] m_err  [DEPTH];
   int          m_scnt = 0;
   int          m_dcnt = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit pow2(input int p);
      return (p == 0) || ((p & (p - 1)) == 0);
   endfunction

   function automatic int bit_of(input int p);
      int c = 0;
      for (int q = 1; q < p; q++) if (!pow2(q)) c++;
      return c;
   endfunction

   function automatic logic [31:0] raw_data(input logic [31:0] d, input logic [38:0] m);
      logic [31:0] r = d;
      for (int p = 1; p < 39; p++) if (m[p] && !pow2(p)) r[bit_of(p)] = ~r[bit_of(p)];
      return r;
   endfunction

   task automatic model_read(input int idx, output logic [31:0] ed, output logic es,
                             output logic edd, output int elat);
      int n = $countones(m_err[idx]);
      es = 1'b0; edd = 1'b0; elat = 3; ed = m_data[idx];
      if (n == 1) begin
         es = 1'b1; elat = 4; m_err[idx] = '0;
         if (m_scnt < 65535) m_scnt++;
      end else if (n >= 2) begin
         edd = 1'b1; ed = raw_data(m_data[idx], m_err[idx]);
         if (m_dcnt < 65535) m_dcnt++;
      end
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) chk({tag, "/ready_timeout"}, 0, 1);
   endtask

   task automatic get_rsp(output int lat, output logic [31:0] rd, output logic s, output logic d);
      lat = 1;
      while (!rsp_valid && lat < 12) begin @(posedge clk); #1; lat++; end
      rd = rsp_rdata; s = s_err; d = d_err;
   endtask

   task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [38:0] inj);
      logic [31:0] ed, rd;
      logic es, edd, s, d;
      int elat, lat, idx;
      idx = int'(addr[IDX_W+1:2]);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; inj_mask = inj;
      wait_ready(tag);
      @(posedge clk); #1;
      req_valid = 1'b0; inj_mask = '0; req_wdata = $urandom;
      get_rsp(lat, rd, s, d);
      if (we) begin
         m_data[idx] = wd; m_err[idx] = inj;
         ed = '0; es = 1'b0; edd = 1'b0; elat = 2;
      end else begin
         model_read(idx, ed, es, edd, elat);
      end
      chk({tag, "/lat"}, lat, elat);
      chk({tag, "/rdata"}, rd, ed);
      chk({tag, "/s_err"}, s, es);
      chk({tag, "/d_err"}, d, edd);
      @(posedge clk); #1;
      chk({tag, "/rsp_one_cycle"}, {rsp_valid, s_err, d_err, req_ready}, 4'b0001);
      chk({tag, "/s_cnt"}, s_cnt, m_scnt);
      chk({tag, "/d_cnt"}, d_cnt, m_dcnt);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ed, rd;
      logic es, edd, s, d;
      int elat, lat;
      logic busy_ok;
      logic [38:0] msk;

      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; inj_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin m_data[i] = '0; m_err[i] = '0; end
      #12;
      chk("reset/outputs", {rsp_valid, s_err, d_err, rsp_rdata, s_cnt, d_cnt}, '0);
      chk("reset/ready", req_ready, 1);
      @(negedge clk); rst = 1'b1;
      chk("reset/ready_first", req_ready, 1);

      xact("wr_deadbeef", 1, 32'h10, 32'hDEADBEEF, '0);
      xact("rd_deadbeef", 0, 32'h10, '0, '0);
      xact("wr_inj5",     1, 32'h20, 32'h12345678, 39'h20);
      xact("rd_inj5",     0, 32'h20, '0, '0);
      xact("rd_scrubbed", 0, 32'h20, '0, '0);
      xact("wr_inj3_9",   1, 32'h40, 32'hA5A5A5A5, 39'h208);
      xact("rd_inj3_9",   0, 32'h40, '0, '0);
      xact("wr_inj0",     1, 32'h50, 32'h0F0F1234, 39'h1);
      xact("rd_inj0",     0, 32'h50, '0, '0);

      // Held req_valid: second read (aliased address) waits for the first response.
      xact("wr_alias", 1, 32'h104, 32'hCAFEF00D, '0);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h04;
      wait_ready("hold");
      @(posedge clk); #1;
      req_addr = 32'h104;
      model_read(1, ed, es, edd, elat);
      lat = 1; busy_ok = 1'b1;
      while (!rsp_valid && lat < 12) begin
         if (req_ready) busy_ok = 1'b0;
         @(posedge clk); #1; lat++;
      end
      chk("hold/busy_not_ready", busy_ok, 1);
      chk("hold/lat1", lat, elat);
      chk("hold/rdata1", rsp_rdata, ed);
      chk("hold/ready_in_resp", req_ready, 0);
      @(posedge clk); #1;
      chk("hold/ready_after_rsp", req_ready, 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      get_rsp(lat, rd, s, d);
      model_read(1, ed, es, edd, elat);
      chk("hold/lat2", lat, elat);
      chk("hold/rdata2", rd, ed);
      @(posedge clk); #1;

      // Reset during the ACCESS cycle of a write must drop the write.
      xact("wr_1111", 1, 32'h30, 32'h1111, '0);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h2222; inj_mask = '0;
      wait_ready("rst");
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b0; #1;
      chk("rst/outputs", {rsp_valid, s_err, d_err, rsp_rdata, s_cnt, d_cnt}, '0);
      @(posedge clk); #1;
      @(negedge clk); rst = 1'b1; m_scnt = 0; m_dcnt = 0;
      chk("rst/ready_first", req_ready, 1);
      xact("rd_1111", 0, 32'h30, '0, '0);

      // Randomized traffic over 8 word indices with random alias bits and 0..2 injected flips.
      for (int i = 0; i < 8; i++)
         xact("rnd_init", 1, {$urandom_range(0, 255), 24'h0} | (i << 2) | $urandom_range(0, 3),
              $urandom, '0);
      for (int n = 0; n < 60; n++) begin
         logic [31:0] a;
         int k, p1, p2;
         a = ({$urandom} & ~32'hFC) | ($urandom_range(0, 7) << 2);
         msk = '0;
         k = $urandom_range(0, 2);
         p1 = $urandom_range(0, 38);
         p2 = (p1 + $urandom_range(1, 38)) % 39;
         if (k >= 1) msk[p1] = 1'b1;
         if (k == 2) msk[p2] = 1'b1;
         if ($urandom_range(0, 1) == 1) xact("rnd_wr", 1, a, $urandom, msk);
         else                            xact("rnd_rd", 0, a, '0, '0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
